// File: rtl/gp_regfile_bus.sv
// gp_regfile_bus: parametrised register file, two registered read ports, dump engine.
// Define GP_REGFILE_BYPASS_EN for write-through forwarding on same-cycle reads.
module gp_regfile_bus #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ZERO_R0  = 0,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_sel_a,
    input  logic [SEL_W-1:0]  rd_sel_b,
    output logic [DATA_W-1:0] bus_out_a,
    output logic [DATA_W-1:0] bus_out_b,
    input  logic              dump_start,
    output logic              dump_valid,
    output logic [SEL_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [SEL_W-1:0]  idx_nx;
    logic              dump_ld;
    logic              wr_ok;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Index addresses a real register (not past the end, not a hardwired R0).
    function automatic logic sel_ok(input logic [SEL_W-1:0] s);
        return (32'(s) < NUM_REGS) && !((ZERO_R0 != 0) && (s == '0));
    endfunction

    // Read value seen by any port this cycle, honouring the forwarding build.
    function automatic logic [DATA_W-1:0] rd_val(input logic [SEL_W-1:0] s);
        logic [DATA_W-1:0] v;
        v = '0;
        if (sel_ok(s)) begin
            v = regs[s];
`ifdef GP_REGFILE_BYPASS_EN
            if (wr_ok && (s == wr_sel)) v = wr_data;
`endif
        end
        return v;
    endfunction

    assign wr_ok = wr_en && sel_ok(wr_sel);

    // Register array; dropped writes never touch storage.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_sel] <= wr_data;
        end
    end

    // Registered A/B read-out, one cycle behind the selects.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_out_a <= '0;
            bus_out_b <= '0;
        end else begin
            bus_out_a <= rd_val(rd_sel_a);
            bus_out_b <= rd_val(rd_sel_b);
        end
    end

    // Dump state, index and data; data is loaded alongside its index.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            state    <= state_nx;
            dump_idx <= idx_nx;
            if (dump_ld) dump_data <= rd_val(idx_nx);
        end
    end

    // Next dump state and index; index 0 is read on the start edge.
    always_comb begin
        state_nx = state;
        idx_nx   = '0;
        dump_ld  = 1'b0;
        unique case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nx = DUMP;
                    dump_ld  = 1'b1;
                end
            end
            DUMP: begin
                if (32'(dump_idx) == NUM_REGS - 1) begin
                    state_nx = DONE;
                end else begin
                    idx_nx  = dump_idx + SEL_W'(1);
                    dump_ld = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign dump_valid = (state == DUMP);
    assign dump_done  = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_gp_regfile_bus.sv
// tb_gp_regfile_bus: scoreboard bench for gp_regfile_bus.
// u0 uses defaults; u1 is NUM_REGS=12, ZERO_R0=1 on the same stimulus.
module tb_gp_regfile_bus;

    localparam int DW = 32;
    localparam int SW = 4;
`ifdef GP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [SW-1:0] idx;
        logic [DW-1:0] data;
    } dw_t;

    logic          clock      = 1'b0;
    logic          clear      = 1'b1;
    logic          wr_en      = 1'b0;
    logic [SW-1:0] wr_sel     = '0;
    logic [DW-1:0] wr_data    = '0;
    logic [SW-1:0] rd_sel_a   = '0;
    logic [SW-1:0] rd_sel_b   = '0;
    logic          dump_start = 1'b0;

    logic [DW-1:0] a0, b0, d0, a1, b1, d1;
    logic [SW-1:0] i0, i1;
    logic          v0, dn0, bz0, v1, dn1, bz1;

    int   n_vec = 0;
    int   n_bad = 0;
    int   busy0 = 0, busy1 = 0, done0 = 0, done1 = 0;
    logic chk   = 1'b0;
    logic chk_q = 1'b0;

    logic [DW-1:0] q_a0[$], q_b0[$], q_a1[$], q_b1[$];
    dw_t           q_d0[$], q_d1[$];

    gp_regfile_bus u0 (
        .clock(clock), .clear(clear),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .bus_out_a(a0), .bus_out_b(b0),
        .dump_start(dump_start), .dump_valid(v0), .dump_idx(i0),
        .dump_data(d0), .dump_done(dn0), .busy(bz0)
    );

    gp_regfile_bus #(.NUM_REGS(12), .ZERO_R0(1)) u1 (
        .clock(clock), .clear(clear),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .bus_out_a(a1), .bus_out_b(b1),
        .dump_start(dump_start), .dump_valid(v1), .dump_idx(i1),
        .dump_data(d1), .dump_done(dn1), .busy(bz1)
    );

    always #5 clock = ~clock;

    function automatic bit in1(input int x);
        return (x >= 1) && (x <= 11);
    endfunction

    task automatic cmp(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: output seen with no expected entry", nm);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic we, input logic [SW-1:0] ws,
                       input logic [DW-1:0] wd,
                       input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                       input logic ck,
                       input logic [DW-1:0] ea0, input logic [DW-1:0] eb0,
                       input logic [DW-1:0] ea1, input logic [DW-1:0] eb1);
        wr_en    = we;
        wr_sel   = ws;
        wr_data  = wd;
        rd_sel_a = sa;
        rd_sel_b = sb;
        chk      = ck;
        if (ck) begin
            q_a0.push_back(ea0);
            q_b0.push_back(eb0);
            q_a1.push_back(ea1);
            q_b1.push_back(eb1);
        end
        tick();
        wr_en = 1'b0;
        chk   = 1'b0;
    endtask

    task automatic wr(input logic [SW-1:0] ws, input logic [DW-1:0] wd);
        cyc(1'b1, ws, wd, '0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic rd(input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                      input logic [DW-1:0] ea0, input logic [DW-1:0] eb0,
                      input logic [DW-1:0] ea1, input logic [DW-1:0] eb1);
        cyc(1'b0, '0, '0, sa, sb, 1'b1, ea0, eb0, ea1, eb1);
    endtask

    task automatic exp_dump(input logic [DW-1:0] base, input bit zero);
        dw_t e;
        for (int i = 0; i < 16; i++) begin
            e.idx  = SW'(i);
            e.data = zero ? '0 : base + DW'(i);
            q_d0.push_back(e);
        end
        for (int i = 0; i < 12; i++) begin
            e.idx  = SW'(i);
            e.data = (zero || i == 0) ? '0 : base + DW'(i);
            q_d1.push_back(e);
        end
    endtask

    task automatic pulse_start();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((bz0 || bz1) && k < 40) begin
            tick();
            k++;
        end
        cmp(nm, DW'(bz0 | bz1), '0);
    endtask

    task automatic sampler();
        forever begin
            @(posedge clock);
            chk_q = chk;
        end
    endtask

    task automatic monitor();
        dw_t e;
        forever begin
            @(negedge clock);
            if (chk_q) begin
                if (q_a0.size() > 0) cmp("bus_a0", a0, q_a0.pop_front());
                else miss("bus_a0");
                if (q_b0.size() > 0) cmp("bus_b0", b0, q_b0.pop_front());
                else miss("bus_b0");
                if (q_a1.size() > 0) cmp("bus_a1", a1, q_a1.pop_front());
                else miss("bus_a1");
                if (q_b1.size() > 0) cmp("bus_b1", b1, q_b1.pop_front());
                else miss("bus_b1");
            end
            if (v0) begin
                if (q_d0.size() > 0) begin
                    e = q_d0.pop_front();
                    cmp("dump_idx0", DW'(i0), DW'(e.idx));
                    cmp("dump_data0", d0, e.data);
                end else miss("dump0");
            end
            if (v1) begin
                if (q_d1.size() > 0) begin
                    e = q_d1.pop_front();
                    cmp("dump_idx1", DW'(i1), DW'(e.idx));
                    cmp("dump_data1", d1, e.data);
                end else miss("dump1");
            end
            if (bz0) busy0++;
            if (bz1) busy1++;
            if (dn0) done0++;
            if (dn1) done1++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0c, b1c, d0c, d1c;
        bit found;

        fork
            sampler();
            monitor();
        join_none

        #2;
        cmp("rst_a0", a0, '0);
        cmp("rst_b0", b0, '0);
        cmp("rst_d0", d0, '0);
        cmp("rst_i0", DW'(i0), '0);
        cmp("rst_flags0", DW'({v0, dn0, bz0}), '0);
        cmp("rst_flags1", DW'({v1, dn1, bz1}), '0);
        tick();
        tick();
        clear = 1'b0;

        for (int i = 0; i < 16; i++) wr(SW'(i), 32'hA5A5_0000 + DW'(i));
        rd(4'd3, 4'd9, 32'hA5A5_0003, 32'hA5A5_0009, 32'hA5A5_0003, 32'hA5A5_0009);
        rd(4'd0, 4'd12, 32'hA5A5_0000, 32'hA5A5_000C, '0, '0);
        @(negedge clock);
        #1;
        clear = 1'b1;
        #1;
        cmp("clr_a0", a0, '0);
        cmp("clr_b0", b0, '0);
        cmp("clr_busy0", DW'(bz0), '0);
        tick();
        tick();
        clear = 1'b0;
        for (int i = 0; i < 16; i++) rd(SW'(i), SW'(15 - i), '0, '0, '0, '0);

        for (int i = 0; i < 16; i++) wr(SW'(i), DW'(i));
        for (int i = 0; i < 16; i++)
            rd(SW'(i), SW'(15 - i), DW'(i), DW'(15 - i),
               in1(i) ? DW'(i) : '0, in1(15 - i) ? DW'(15 - i) : '0);

        cyc(1'b1, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd6, 1'b1,
            BYP ? 32'hDEAD_BEEF : 32'd5, 32'd6,
            BYP ? 32'hDEAD_BEEF : 32'd5, 32'd6);
        rd(4'd5, 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        cyc(1'b1, 4'd0, 32'd7, 4'd0, 4'd1, 1'b1,
            BYP ? 32'd7 : 32'd0, 32'd1, 32'd0, 32'd1);
        rd(4'd0, 4'd0, 32'd7, 32'd7, '0, '0);
        cyc(1'b1, 4'd13, 32'hBAD, 4'd13, 4'd1, 1'b1,
            BYP ? 32'hBAD : 32'd13, 32'd1, 32'd0, 32'd1);
        rd(4'd14, 4'd13, 32'd14, 32'hBAD, '0, '0);
        rd(4'd1, 4'd11, 32'd1, 32'd11, 32'd1, 32'd11);

        for (int i = 0; i < 16; i++) wr(SW'(i), 32'h100 + DW'(i));
        b0c = busy0;
        b1c = busy1;
        d0c = done0;
        d1c = done1;
        exp_dump(32'h100, 1'b0);
        pulse_start();
        repeat (4) tick();
        pulse_start();
        wait_idle("dump1_timeout");
        cmp("busy_cycles0", DW'(busy0 - b0c), 32'd17);
        cmp("done_pulses0", DW'(done0 - d0c), 32'd1);
        cmp("busy_cycles1", DW'(busy1 - b1c), 32'd13);
        cmp("done_pulses1", DW'(done1 - d1c), 32'd1);
        cmp("dump_left0", DW'(q_d0.size()), '0);
        cmp("dump_left1", DW'(q_d1.size()), '0);
        cmp("idle_idx0", DW'(i0), '0);
        cmp("idle_valid0", DW'(v0), '0);
        cmp("hold_data0", d0, 32'h10F);
        cmp("hold_data1", d1, 32'h10B);

        exp_dump(32'h100, 1'b0);
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (v0 && i0 == 4'd6) begin
                found = 1'b1;
                break;
            end
        end
        cmp("reach_idx6", DW'(found), 32'd1);
        #1;
        clear = 1'b1;
        #1;
        cmp("abort_busy0", DW'(bz0), '0);
        cmp("abort_valid0", DW'(v0), '0);
        cmp("abort_busy1", DW'(bz1), '0);
        cmp("abort_valid1", DW'(v1), '0);
        cmp("abort_data0", d0, '0);
        q_d0.delete();
        q_d1.delete();
        tick();
        clear = 1'b0;
        exp_dump('0, 1'b1);
        pulse_start();
        wait_idle("dump2_timeout");
        cmp("restart_left0", DW'(q_d0.size()), '0);
        cmp("restart_left1", DW'(q_d1.size()), '0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
